// File: rtl/reg_counter_bank.sv
// Register bank of 2**BIT_ADDR counters with prescaled inc/dec/load,
// two combinational read ports, a sequenced bulk clear and req/ack handshake.
module reg_counter_bank #(
  parameter int BIT_ADDR      = 4,
  parameter int BIT_DATO      = 3,
  parameter int PRESCALE_BITS = 6,
  parameter int SATURATE      = 0,
  parameter int RST_VAL       = 0,
  parameter     INIT_FILE     = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_ADDR-1:0] addr_a,
  output logic [BIT_DATO-1:0] rd_a,
  input  logic [BIT_ADDR-1:0] addr_b,
  output logic [BIT_DATO-1:0] rd_b,
  input  logic                wr_req,
  input  logic [1:0]          wr_op,
  input  logic [BIT_ADDR-1:0] wr_addr,
  input  logic [BIT_DATO-1:0] wr_data,
  output logic                wr_ack,
  output logic                ovf,
  input  logic                clr_req,
  output logic                clr_done,
  output logic                busy
);

  localparam int unsigned         NREG = 2**BIT_ADDR;
  localparam logic [BIT_DATO-1:0] RV   = BIT_DATO'(RST_VAL);
  localparam logic [BIT_DATO-1:0] MAXV = '1;
  localparam logic [BIT_ADDR-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, PEND, CLEAR} state_t;

  state_t              state, state_n;
  logic [BIT_DATO-1:0] breg [NREG];
  logic [BIT_ADDR-1:0] lat_addr;
  logic [1:0]          lat_op;
  logic [BIT_DATO-1:0] lat_data;
  logic [BIT_ADDR-1:0] clr_idx;
  logic                tick;
  logic [BIT_DATO-1:0] cur_val, upd_val;
  logic                upd_ovf;
  logic                ack_n, ovf_n, done_n, latch_en, apply_en;

  // Prescaler: free-running counter, tick when all-ones (always ticking when width is 0)
  generate
    if (PRESCALE_BITS == 0) begin : g_nopre
      assign tick = 1'b1;
    end else begin : g_pre
      logic [PRESCALE_BITS-1:0] pcnt;
      // Free-running prescale counter
      always_ff @(posedge clk) begin
        if (rst) pcnt <= '0;
        else     pcnt <= pcnt + 1'b1;
      end
      assign tick = &pcnt;
    end
  endgenerate

  assign rd_a = breg[addr_a];
  assign rd_b = breg[addr_b];
  assign busy = (state != IDLE);
  assign cur_val = breg[lat_addr];

  // Arithmetic for the latched operation, with wrap or clamp and overflow flag
  always_comb begin
    upd_val = cur_val;
    upd_ovf = 1'b0;
    case (lat_op)
      2'b01: begin
        if (cur_val == MAXV) begin
          upd_ovf = 1'b1;
          upd_val = (SATURATE != 0) ? MAXV : '0;
        end else begin
          upd_val = cur_val + 1'b1;
        end
      end
      2'b10: begin
        if (cur_val == '0) begin
          upd_ovf = 1'b1;
          upd_val = (SATURATE != 0) ? '0 : MAXV;
        end else begin
          upd_val = cur_val - 1'b1;
        end
      end
      2'b11:   upd_val = lat_data;
      default: upd_val = cur_val;
    endcase
  end

  // Next-state and pulse decode; clr_req takes priority over wr_req in IDLE
  always_comb begin
    state_n  = state;
    ack_n    = 1'b0;
    ovf_n    = 1'b0;
    done_n   = 1'b0;
    latch_en = 1'b0;
    apply_en = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_n = CLEAR;
        end else if (wr_req) begin
          if (wr_op != 2'b00) begin
            state_n  = PEND;
            latch_en = 1'b1;
          end else begin
            ack_n = 1'b1;
          end
        end
      end
      PEND: begin
        if (tick) begin
          state_n  = IDLE;
          apply_en = 1'b1;
          ack_n    = 1'b1;
          ovf_n    = upd_ovf;
        end
      end
      CLEAR: begin
        if (clr_idx == LAST) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, request latch, sweep index and registered handshake pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_op   <= '0;
      lat_data <= '0;
      clr_idx  <= '0;
      wr_ack   <= 1'b0;
      ovf      <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_n;
      wr_ack   <= ack_n;
      ovf      <= ovf_n;
      clr_done <= done_n;
      if (latch_en) begin
        lat_addr <= wr_addr;
        lat_op   <= wr_op;
        lat_data <= wr_data;
      end
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
      else                clr_idx <= '0;
    end
  end

  // Entry storage: reset fill, one-entry-per-cycle clear sweep, prescaled op apply
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) breg[i] <= RV;
    end else if (state == CLEAR) begin
      breg[clr_idx] <= RV;
    end else if (apply_en) begin
      breg[lat_addr] <= upd_val;
    end
  end

endmodule

// File: tb/tb_reg_counter_bank.sv
// Scoreboard bench: two banks (wrap and saturate) driven in lockstep.
module tb_reg_counter_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] addr_a = '0, addr_b = '0, wr_addr = '0;
  logic       wr_req = 1'b0, clr_req = 1'b0;
  logic [1:0] wr_op = '0;
  logic [2:0] wr_data = '0;

  logic [2:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic       wr_ack0, ovf0, clr_done0, busy0;
  logic       wr_ack1, ovf1, clr_done1, busy1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic clr; logic ovf; logic [2:0] val;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int   pc = 0;
  logic last_tick = 1'b0;

  always #5 clk = ~clk;

  reg_counter_bank #(.BIT_ADDR(4), .BIT_DATO(3), .PRESCALE_BITS(2), .SATURATE(0), .RST_VAL(0)) dut0 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .rd_a(rd_a0), .addr_b(addr_b), .rd_b(rd_b0),
    .wr_req(wr_req), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack0), .ovf(ovf0), .clr_req(clr_req), .clr_done(clr_done0), .busy(busy0));

  reg_counter_bank #(.BIT_ADDR(4), .BIT_DATO(3), .PRESCALE_BITS(2), .SATURATE(1), .RST_VAL(0)) dut1 (
    .clk(clk), .rst(rst), .addr_a(addr_a), .rd_a(rd_a1), .addr_b(addr_b), .rd_b(rd_b1),
    .wr_req(wr_req), .wr_op(wr_op), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack1), .ovf(ovf1), .clr_req(clr_req), .clr_done(clr_done1), .busy(busy1));

  // Reference tick: every 4th cycle after reset release
  always @(posedge clk) begin
    last_tick = (pc == 3);
    pc = rst ? 0 : (pc + 1) % 4;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pop an expectation whenever a bank presents wr_ack or clr_done
  always @(negedge clk) begin
    exp_t e;
    if (wr_ack0 === 1'b1 || clr_done0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0_unexpected: ack %0d done %0d with empty queue", wr_ack0, clr_done0);
      end else begin
        e = q0.pop_front();
        chk("d0_done", clr_done0, e.clr);
        chk("d0_ack", wr_ack0, !e.clr);
        if (!e.clr) begin
          chk("d0_ovf", ovf0, e.ovf);
          chk("d0_val", rd_b0, e.val);
        end
      end
    end
    if (wr_ack1 === 1'b1 || clr_done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected: ack %0d done %0d with empty queue", wr_ack1, clr_done1);
      end else begin
        e = q1.pop_front();
        chk("d1_done", clr_done1, e.clr);
        chk("d1_ack", wr_ack1, !e.clr);
        if (!e.clr) begin
          chk("d1_ovf", ovf1, e.ovf);
          chk("d1_val", rd_b1, e.val);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [2:0] d,
                       input logic [2:0] v0, input logic o0, input logic [2:0] v1, input logic o1);
    int n;
    addr_b = a; wr_op = op; wr_addr = a; wr_data = d; wr_req = 1'b1;
    q0.push_back('{clr: 1'b0, ovf: o0, val: v0});
    q1.push_back('{clr: 1'b0, ovf: o1, val: v1});
    cyc();
    wr_req = 1'b0;
    n = 0;
    while (busy0 && n < 20) begin
      if (n > 0) chk("pend_past_tick", last_tick, 0);
      cyc();
      n++;
    end
    if (busy0) chk("op_timeout", busy0, 0);
    else if (op != 2'b00) chk("ack_on_tick", last_tick, 1);
    cyc();
  endtask

  task automatic all_rst(input string nm);
    for (int i = 0; i < 16; i++) begin
      addr_a = 4'(i);
      #1;
      chk(nm, rd_a0, 0);
      chk(nm, rd_a1, 0);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    // Reset state
    chk("rst_busy", busy0, 0);
    chk("rst_ack", wr_ack0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_done", clr_done0, 0);
    all_rst("rst_entry");

    // First op: inc @5 must not update before the tick
    addr_b = 4'd5; wr_op = 2'b01; wr_addr = 4'd5; wr_req = 1'b1;
    q0.push_back('{clr: 1'b0, ovf: 1'b0, val: 3'd1});
    q1.push_back('{clr: 1'b0, ovf: 1'b0, val: 3'd1});
    cyc();
    wr_req = 1'b0;
    chk("pend_busy", busy0, 1);
    chk("pend_old_val", rd_b0, 0);
    n = 0;
    while (busy0 && n < 20) begin
      if (n > 0) chk("pend_past_tick", last_tick, 0);
      cyc();
      n++;
    end
    chk("first_ack_on_tick", last_tick, 1);
    chk("first_ack_pulse", wr_ack0, 1);
    cyc();
    chk("ack_one_cycle", wr_ack0, 0);

    // Wrap vs saturate arithmetic on entry 3
    do_op(2'b11, 4'd3, 3'd7, 3'd7, 1'b0, 3'd7, 1'b0);
    do_op(2'b01, 4'd3, 3'd0, 3'd0, 1'b1, 3'd7, 1'b1);
    do_op(2'b10, 4'd3, 3'd0, 3'd7, 1'b1, 3'd6, 1'b0);
    do_op(2'b11, 4'd3, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    do_op(2'b10, 4'd3, 3'd0, 3'd7, 1'b1, 3'd0, 1'b1);
    do_op(2'b11, 4'd3, 3'd4, 3'd4, 1'b0, 3'd4, 1'b0);
    do_op(2'b01, 4'd3, 3'd0, 3'd5, 1'b0, 3'd5, 1'b0);
    do_op(2'b00, 4'd3, 3'd2, 3'd5, 1'b0, 3'd5, 1'b0);

    // Simultaneous clr_req and wr_req: clear wins, write never acked
    q0.push_back('{clr: 1'b1, ovf: 1'b0, val: 3'd0});
    q1.push_back('{clr: 1'b1, ovf: 1'b0, val: 3'd0});
    clr_req = 1'b1; wr_req = 1'b1; wr_op = 2'b11; wr_addr = 4'd0; wr_data = 3'd3;
    cyc();
    clr_req = 1'b0; wr_req = 1'b0;
    wait_idle(n);
    chk("clr_busy_cycles", n, 16);
    chk("clr_done_pulse", clr_done0, 1);
    cyc();
    all_rst("clr_entry");

    // Reset in the middle of PEND
    do_op(2'b11, 4'd1, 3'd6, 3'd6, 1'b0, 3'd6, 1'b0);
    wr_op = 2'b01; wr_addr = 4'd1; wr_req = 1'b1;
    cyc();
    wr_req = 1'b0;
    chk("midpend_busy", busy0, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstpend_busy", busy0, 0);
    chk("rstpend_ack", wr_ack0, 0);
    all_rst("rstpend_entry");
    repeat (8) cyc();

    // Reset in the middle of CLEAR
    do_op(2'b11, 4'd7, 3'd2, 3'd2, 1'b0, 3'd2, 1'b0);
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (5) cyc();
    chk("midclr_busy", busy0, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstclr_busy", busy0, 0);
    chk("rstclr_done", clr_done0, 0);
    all_rst("rstclr_entry");
    repeat (20) cyc();

    // Requests while busy are ignored
    q0.push_back('{clr: 1'b1, ovf: 1'b0, val: 3'd0});
    q1.push_back('{clr: 1'b1, ovf: 1'b0, val: 3'd0});
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    repeat (3) cyc();
    wr_req = 1'b1; wr_op = 2'b11; wr_addr = 4'd2; wr_data = 3'd5; clr_req = 1'b1;
    cyc();
    wr_req = 1'b0; clr_req = 1'b0;
    wait_idle(n);
    cyc();
    addr_a = 4'd2; #1;
    chk("busy_wr_ignored", rd_a0, 0);
    chk("busy_clr_ignored", busy0, 0);

    // Dual read
    do_op(2'b11, 4'd2, 3'd1, 3'd1, 1'b0, 3'd1, 1'b0);
    do_op(2'b11, 4'd9, 3'd6, 3'd6, 1'b0, 3'd6, 1'b0);
    addr_a = 4'd2; addr_b = 4'd9; #1;
    chk("dual_rd_a0", rd_a0, 1);
    chk("dual_rd_b0", rd_b0, 6);
    chk("dual_rd_a1", rd_a1, 1);
    chk("dual_rd_b1", rd_b1, 6);
    addr_b = 4'd2; #1;
    chk("same_addr_b0", rd_b0, 1);

    repeat (5) cyc();
    chk("d0_pending", q0.size(), 0);
    chk("d1_pending", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
